// File: rtl/input_stream_loader_pkg.sv
// Shared NPU loader definitions: frame geometry and launcher state encoding.
package input_stream_loader_pkg;

  localparam int FRAME_BYTES = 5;

  // Byte 0..3 are lanes DA..DD, byte 4 is the bias.
  typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_START = 2'd1,
    L_WAIT  = 2'd2
  } lstate_e;

endpackage

// File: rtl/stream_collector.sv
// Staging side of the loader: assembles 5-byte frames from the byte stream,
// discards a partial frame after an inter-byte timeout.
module stream_collector
  import input_stream_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       stage_clr,
  output frame_t     stage_data,
  output logic       stage_full,
  output logic       to_pulse
);

  localparam int IW = $clog2(FRAME_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);

  frame_t        stage_q, stage_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          full_q, full_d;
  logic          xfer;

  assign s_ready    = ~full_q;
  assign stage_data = stage_q;
  assign stage_full = full_q;

  // Byte capture, frame completion and idle down-counter for partial frames.
  always_comb begin
    stage_d  = stage_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    full_d   = full_q;
    to_pulse = 1'b0;
    xfer     = s_valid & ~full_q;

    // Launcher only clears while full, so this never coincides with a transfer.
    if (stage_clr) full_d = 1'b0;

    if (xfer) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        if (idx_q == IW'(i)) stage_d[i] = s_data;
      end
      to_cnt_d = TO_LOAD;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else if (idx_q != '0) begin
      if (to_cnt_q == '0) begin
        to_pulse = 1'b1;
        idx_d    = '0;
        to_cnt_d = TO_LOAD;
      end else begin
        to_cnt_d = to_cnt_q - TW'(1);
      end
    end
  end

  // Collector state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= '0;
      idx_q    <= '0;
      to_cnt_q <= TO_LOAD;
      full_q   <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      full_q   <= full_d;
    end
  end

endmodule

// File: rtl/input_stream_loader.sv
// NPU input loader: double-buffered frame collector plus launcher FSM that
// presents held lane/bias data, pulses START and waits for DONE.
//
// state   | meaning
// L_IDLE  | outputs held; launch as soon as the staging buffer is full
// L_START | one-cycle START pulse, outputs just copied from staging
// L_WAIT  | awaiting DONE, watchdog counting down
module input_stream_loader
  import input_stream_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int WAIT_MAX    = 255
) (
  input  logic       CLKEXT,
  input  logic       RST_GLO,
  input  logic [7:0] S_DATA,
  input  logic       S_VALID,
  output logic       S_READY,
  input  logic       DONE,
  input  logic       CLR_ERR,
  output logic [7:0] DA,
  output logic [7:0] DB,
  output logic [7:0] DC,
  output logic [7:0] DD,
  output logic [7:0] BIAS_IN,
  output logic       START,
  output logic       LD_BUSY,
  output logic [7:0] FRAME_CNT,
  output logic       ERR_TO,
  output logic       ERR_WD
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WD_LOAD = WW'(WAIT_MAX - 1);

  lstate_e       state_q, state_d;
  frame_t        lane_q, lane_d;
  frame_t        stage_data;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          err_to_q, err_to_d;
  logic          err_wd_q, err_wd_d;
  logic          stage_full, to_pulse, launch, wd_hit;

  stream_collector #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_collector (
    .clk        (CLKEXT),
    .rst        (RST_GLO),
    .s_data     (S_DATA),
    .s_valid    (S_VALID),
    .s_ready    (S_READY),
    .stage_clr  (launch),
    .stage_data (stage_data),
    .stage_full (stage_full),
    .to_pulse   (to_pulse)
  );

  // Launcher next-state, output copy, watchdog and sticky error flags.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    wd_cnt_d    = wd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    launch      = 1'b0;
    wd_hit      = 1'b0;

    case (state_q)
      L_IDLE: begin
        if (stage_full) begin
          launch      = 1'b1;
          lane_d      = stage_data;
          frame_cnt_d = frame_cnt_q + 8'd1;
          start_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = L_START;
        end
      end
      L_START: begin
        wd_cnt_d = WD_LOAD;
        state_d  = L_WAIT;
      end
      L_WAIT: begin
        if (DONE) begin
          busy_d  = 1'b0;
          state_d = L_IDLE;
        end else if (wd_cnt_q == '0) begin
          wd_hit  = 1'b1;
          busy_d  = 1'b0;
          state_d = L_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q - WW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = L_IDLE;
      end
    endcase

    // A new error in the same cycle as CLR_ERR stays set.
    err_to_d = to_pulse ? 1'b1 : (CLR_ERR ? 1'b0 : err_to_q);
    err_wd_d = wd_hit   ? 1'b1 : (CLR_ERR ? 1'b0 : err_wd_q);
  end

  // Launcher registers.
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state_q     <= L_IDLE;
      lane_q      <= '0;
      wd_cnt_q    <= WD_LOAD;
      frame_cnt_q <= 8'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_wd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      wd_cnt_q    <= wd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      err_to_q    <= err_to_d;
      err_wd_q    <= err_wd_d;
    end
  end

  assign DA        = lane_q[0];
  assign DB        = lane_q[1];
  assign DC        = lane_q[2];
  assign DD        = lane_q[3];
  assign BIAS_IN   = lane_q[4];
  assign START     = start_q;
  assign LD_BUSY   = busy_q;
  assign FRAME_CNT = frame_cnt_q;
  assign ERR_TO    = err_to_q;
  assign ERR_WD    = err_wd_q;

endmodule

// File: tb/tb_input_stream_loader.sv
// Bench for input_stream_loader: vector table, corner-case sequences and a
// randomized frame stream checked against a frame-level reference model.
module tb_input_stream_loader;

  localparam int TO_CYC = 16;
  localparam int WD_MAX = 255;

  logic       CLKEXT  = 1'b0;
  logic       RST_GLO = 1'b1;
  logic [7:0] S_DATA  = 8'h00;
  logic       S_VALID = 1'b0;
  logic       DONE    = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       S_READY, START, LD_BUSY, ERR_TO, ERR_WD;
  logic [7:0] DA, DB, DC, DD, BIAS_IN, FRAME_CNT;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int start_count = 0;

  typedef struct packed {
    logic [4:0][7:0] bytes_in;   // [0]=first byte on the stream
    logic [4:0][7:0] exp_lanes;  // DA, DB, DC, DD, BIAS_IN
    logic [7:0]      exp_cnt;
  } vec_t;

  vec_t vecs[3];

  input_stream_loader #(.TIMEOUT_CYC(TO_CYC), .WAIT_MAX(WD_MAX)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_READY(S_READY), .DONE(DONE), .CLR_ERR(CLR_ERR), .DA(DA), .DB(DB),
    .DC(DC), .DD(DD), .BIAS_IN(BIAS_IN), .START(START), .LD_BUSY(LD_BUSY),
    .FRAME_CNT(FRAME_CNT), .ERR_TO(ERR_TO), .ERR_WD(ERR_WD)
  );

  always #5 CLKEXT = ~CLKEXT;
  always @(posedge CLKEXT) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLKEXT) begin
    if (START === 1'b1) begin
      start_count++;
      chk("busy_with_start", LD_BUSY, 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n = 0;
    S_DATA  = b;
    S_VALID = 1'b1;
    while (!S_READY && n < 400) begin
      tick();
      n++;
    end
    if (!S_READY) chk("ready_wait", 0, 1);
    acc = cyc;
    tick();
    S_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [4:0][7:0] f, input int maxgap, output int last);
    for (int i = 0; i < 5; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) tick();
      send_byte(f[i], last);
    end
  endtask

  task automatic wait_start(output int c);
    c = -1;
    for (int i = 0; i < 20; i++) begin
      if (START === 1'b1) begin
        c = cyc;
        break;
      end
      tick();
    end
    if (c < 0) chk("start_seen", 0, 1);
  endtask

  task automatic chk_outs(input string nm, input logic [4:0][7:0] f, input logic [7:0] cnt);
    chk({nm, "_DA"}, DA, f[0]);
    chk({nm, "_DB"}, DB, f[1]);
    chk({nm, "_DC"}, DC, f[2]);
    chk({nm, "_DD"}, DD, f[3]);
    chk({nm, "_BIAS"}, BIAS_IN, f[4]);
    chk({nm, "_CNT"}, FRAME_CNT, cnt);
  endtask

  task automatic pulse_done;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
  endtask

  task automatic do_reset;
    RST_GLO = 1'b1;
    tick();
    tick();
    RST_GLO = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk_outs(nm, '0, 8'd0);
    chk({nm, "_START"}, START, 0);
    chk({nm, "_BUSY"}, LD_BUSY, 0);
    chk({nm, "_ERRTO"}, ERR_TO, 0);
    chk({nm, "_ERRWD"}, ERR_WD, 0);
    chk({nm, "_READY"}, S_READY, 1);
  endtask

  initial begin
    int last, c, acc, sc;
    logic [4:0][7:0] f1, f2;
    logic [7:0] cnt_m;
    bit err_to_m;

    vecs[0] = '{bytes_in: {8'h05, 8'h44, 8'h33, 8'h22, 8'h11},
                exp_lanes: {8'h05, 8'h44, 8'h33, 8'h22, 8'h11}, exp_cnt: 8'd1};
    vecs[1] = '{bytes_in: {8'h80, 8'h5A, 8'hA5, 8'h00, 8'hFF},
                exp_lanes: {8'h80, 8'h5A, 8'hA5, 8'h00, 8'hFF}, exp_cnt: 8'd2};
    vecs[2] = '{bytes_in: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
                exp_lanes: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, exp_cnt: 8'd3};

    RST_GLO = 1'b1;
    repeat (3) tick();
    RST_GLO = 1'b0;
    chk_zero("reset");

    // Back-to-back frames from the vector table.
    for (int v = 0; v < 3; v++) begin
      send_frame(vecs[v].bytes_in, 0, last);
      wait_start(c);
      chk("latency", c, last + 2);
      chk_outs("vec", vecs[v].exp_lanes, vecs[v].exp_cnt);
      DONE = 1'b1;                     // ignored while in L_START
      tick();
      DONE = 1'b0;
      chk("start_one_cycle", START, 0);
      chk("busy_after_early_done", LD_BUSY, 1);
      repeat (3) tick();
      chk_outs("vec_hold", vecs[v].exp_lanes, vecs[v].exp_cnt);
      pulse_done();
      chk("busy_after_done", LD_BUSY, 0);
    end

    // Double buffering: second frame collected while the first is in flight.
    f1 = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11};
    f2 = {8'h25, 8'h24, 8'h23, 8'h22, 8'h21};
    send_frame(f1, 0, last);
    wait_start(c);
    send_frame(f2, 0, last);
    chk("ready_low_when_full", S_READY, 0);
    chk_outs("hold_f1", f1, 8'd4);
    repeat (5) tick();
    chk("no_second_start", START, 0);
    acc = cyc;
    pulse_done();
    wait_start(c);
    chk("done_to_start", c, acc + 2);
    chk_outs("f2", f2, 8'd5);
    chk("ready_after_launch", S_READY, 1);
    tick();
    pulse_done();

    // Inter-byte timeout; CLR_ERR held high so set-wins-over-clear is visible.
    send_byte(8'hAA, acc);
    send_byte(8'hBB, acc);
    CLR_ERR = 1'b1;
    repeat (TO_CYC - 1) tick();
    chk("err_to_early", ERR_TO, 0);
    tick();
    chk("err_to_set", ERR_TO, 1);
    tick();
    chk("err_to_clr", ERR_TO, 0);
    CLR_ERR = 1'b0;
    f1 = {8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
    send_frame(f1, 0, last);
    wait_start(c);
    chk("latency_after_to", c, last + 2);
    chk_outs("after_to", f1, 8'd6);
    tick();
    pulse_done();

    // Watchdog expiry, late DONE ignored, then CLR_ERR.
    f1 = {8'h45, 8'h44, 8'h43, 8'h42, 8'h41};
    send_frame(f1, 0, last);
    wait_start(c);
    repeat (WD_MAX) tick();
    chk("wd_busy_before", LD_BUSY, 1);
    chk("wd_err_before", ERR_WD, 0);
    tick();
    chk("wd_busy_after", LD_BUSY, 0);
    chk("wd_err_after", ERR_WD, 1);
    sc = start_count;
    pulse_done();
    repeat (3) tick();
    chk("late_done_no_start", start_count, sc);
    chk("wd_err_sticky", ERR_WD, 1);
    chk_outs("wd_hold", f1, 8'd7);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("wd_err_clr", ERR_WD, 0);

    // Reset mid-frame, then a fresh frame.
    send_byte(8'h91, acc);
    send_byte(8'h92, acc);
    send_byte(8'h93, acc);
    sc = start_count;
    do_reset();
    chk_zero("rst_mid");
    repeat (4) tick();
    chk("rst_mid_no_start", start_count, sc);
    send_frame(vecs[0].bytes_in, 0, last);
    wait_start(c);
    chk("latency_after_rst", c, last + 2);
    chk_outs("after_rst", vecs[0].exp_lanes, 8'd1);
    tick();

    // Reset while in L_WAIT.
    sc = start_count;
    do_reset();
    chk_zero("rst_wait");
    repeat (4) tick();
    chk("rst_wait_no_start", start_count, sc);

    // Random stream: 256 frames with gaps, injected timeouts and random CLR_ERR.
    cnt_m    = 8'd0;
    err_to_m = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        int nb;
        nb = $urandom_range(1, 4);
        for (int j = 0; j < nb; j++) send_byte(8'($urandom), acc);
        repeat (TO_CYC + 1) tick();
        err_to_m = 1'b1;
      end
      for (int j = 0; j < 5; j++) f1[j] = 8'($urandom);
      send_frame(f1, 3, last);
      wait_start(c);
      cnt_m = cnt_m + 8'd1;
      chk("rnd_latency", c, last + 2);
      chk_outs("rnd", f1, cnt_m);
      chk("rnd_err_to", ERR_TO, err_to_m);
      tick();
      repeat ($urandom_range(0, 5)) tick();
      pulse_done();
      chk("rnd_busy_done", LD_BUSY, 0);
      if ($urandom_range(0, 3) == 0) begin
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        err_to_m = 1'b0;
      end
    end
    chk("frame_cnt_wrap", FRAME_CNT, 0);
    chk("rnd_err_wd", ERR_WD, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_stream_loader.md
INPUT_STREAM_LOADER -- requirements
Module: input_stream_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, max idle cycles between bytes of a partial frame.
REQ-002 SHALL have parameter WAIT_MAX, default 255, max cycles awaiting DONE after START.
REQ-003 SHALL have one clock and a synchronous, active-high reset, per the ports below.
REQ-004 CLKEXT  in  1  sole clock; all logic on rising edge.
REQ-005 RST_GLO  in  1  reset; synchronous, active-high.
REQ-006 S_DATA  in  8  inbound byte stream.
REQ-007 S_VALID  in  1  S_DATA valid.
REQ-008 S_READY  out  1  loader accepts a byte this cycle.
REQ-009 DONE  in  1  one-cycle completion pulse from the NPU controller.
REQ-010 CLR_ERR  in  1  clears sticky error flags.
REQ-011 DA, DB, DC, DD  out  8 each  lane data held for the NPU.
REQ-012 BIAS_IN  out  8  bias byte held for the NPU.
REQ-013 START  out  1  registered one-cycle launch pulse.
REQ-014 LD_BUSY  out  1  high from launch until DONE or watchdog expiry.
REQ-015 FRAME_CNT  out  8  count of launched frames, wraps 255->0.
REQ-016 ERR_TO  out  1  sticky: partial frame discarded on inter-byte timeout.
REQ-017 ERR_WD  out  1  sticky: DONE not seen within WAIT_MAX cycles.

Function
REQ-018 Frame SHALL be 5 bytes in order DA, DB, DC, DD, BIAS.
REQ-019 Transfer SHALL occur on cycles with S_VALID=1 and S_READY=1 only.
REQ-020 S_READY SHALL equal !stage_full (combinational).
REQ-021 Collector SHALL write each byte to staging register byte_idx (0..4) and increment byte_idx.
REQ-022 On acceptance at byte_idx=4, collector SHALL set stage_full and reset byte_idx to 0.
REQ-023 Inter-byte timeout: with byte_idx!=0 and no transfer for TIMEOUT_CYC consecutive cycles, collector SHALL reset byte_idx to 0 and set ERR_TO; partial staging data is discarded.
REQ-024 Launcher FSM SHALL have states L_IDLE, L_START, L_WAIT.
REQ-025 In L_IDLE with stage_full=1, launcher SHALL copy staging to DA..DD/BIAS_IN, clear stage_full, increment FRAME_CNT, and go to L_START.
REQ-026 In L_START, START=1 and LD_BUSY=1 for exactly one cycle, then go to L_WAIT.
REQ-027 In L_WAIT, on DONE=1 launcher SHALL go to L_IDLE.
REQ-028 In L_WAIT, after WAIT_MAX cycles without DONE, launcher SHALL set ERR_WD and go to L_IDLE.
REQ-029 DONE outside L_WAIT SHALL be ignored.
REQ-030 DA..DD/BIAS_IN SHALL change only on a launch copy and stay stable through L_START and L_WAIT.
REQ-031 Next frame SHALL be collectable during L_START/L_WAIT (double buffering); if full, it launches in the first cycle the launcher is in L_IDLE.
REQ-032 Launch latency: last byte accepted at cycle N -> START high at cycle N+2 when the launcher is idle.
REQ-033 Stage clear at launch SHALL take effect next cycle; no byte is accepted in the launch-copy cycle.
REQ-034 CLR_ERR SHALL clear both flags; a same-cycle error set SHALL win over CLR_ERR.

Reset
REQ-035 RST_GLO=1 SHALL force L_IDLE, byte_idx=0, stage_full=0, START=0, LD_BUSY=0, S_READY=1 after the edge, DA..DD=0, BIAS_IN=0, FRAME_CNT=0, ERR_TO=0, ERR_WD=0.
REQ-036 Reset mid-frame or in L_WAIT SHALL discard all data with no START pulse.

Structure
REQ-037 FRAME_BYTES=5 and the launcher state encodings (2 bits) SHALL reside in the shared npu package.
REQ-038 The collector SHALL be a sub-module, stream_collector (staging regs, byte_idx, timeout counter, stage_full); the launcher FSM is in the top.

Verification
REQ-039 Bytes 11,22,33,44,05 back-to-back -> START at cycle N+2; DA=11, DB=22, DC=33, DD=44, BIAS_IN=05; FRAME_CNT=1.
REQ-040 Frame 1 launched, frame 2 streamed, no DONE -> S_READY=0 after byte 5; DONE -> frame-2 outputs and START 2 cycles later.
REQ-041 2 bytes then S_VALID=0 for 16 cycles -> ERR_TO=1, byte_idx=0; next 5 bytes form a clean frame.
REQ-042 Launch, withhold DONE 255 cycles -> ERR_WD=1, LD_BUSY=0; CLR_ERR -> ERR_WD=0.
REQ-043 RST_GLO asserted after byte 3 -> all outputs 0, no START; a fresh frame behaves as REQ-039.
REQ-044 256 complete frames with DONE each -> FRAME_CNT wraps to 0.
